// File: rtl/rs_dec_pkg.sv
// Shared constants, FSM state and error-table entry type for the RS error-correction stage.
package rs_dec_pkg;

  localparam int W      = 10;            // symbol bits
  localparam int T      = 11;            // max correctable errors
  localparam int P      = 32;            // symbols per beat
  localparam int N      = 1023;          // full-length code
  localparam int N_CW   = 544;           // shortened codeword length n
  localparam int POS_W  = $clog2(N);
  localparam int BEATS  = N_CW / P;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CORRECT
  } state_t;

  typedef struct packed {
    logic             vld;
    logic [POS_W-1:0] pos;
    logic [W-1:0]     y;
  } entry_t;

endpackage

// File: rtl/rs_err_correct_if.sv
// Handshake/bus bundle of the error-correction stage; slave = DUT view, master = driver view.
interface rs_err_correct_if;
  import rs_dec_pkg::*;

  logic                  start_i;
  logic [3:0]            deg_i;
  logic                  evt_vld_i;
  logic [POS_W-1:0]      evt_pos_i;
  logic [W-1:0]          evt_y_i;
  logic                  evt_den_zero_i;
  logic                  evt_rdy_o;
  logic                  chien_done_i;
  logic                  cw_vld_i;
  logic [P-1:0][W-1:0]   cw_data_i;
  logic                  cw_rdy_o;
  logic                  out_vld_o;
  logic [P-1:0][W-1:0]   out_data_o;
  logic                  out_last_o;
  logic                  out_rdy_i;
  logic                  stat_vld_o;
  logic                  dec_fail_o;
  logic [CNT_W-1:0]      err_cnt_o;

  modport slave (
    input  start_i, deg_i, evt_vld_i, evt_pos_i, evt_y_i, evt_den_zero_i,
           chien_done_i, cw_vld_i, cw_data_i, out_rdy_i,
    output evt_rdy_o, cw_rdy_o, out_vld_o, out_data_o, out_last_o,
           stat_vld_o, dec_fail_o, err_cnt_o
  );

  modport master (
    output start_i, deg_i, evt_vld_i, evt_pos_i, evt_y_i, evt_den_zero_i,
           chien_done_i, cw_vld_i, cw_data_i, out_rdy_i,
    input  evt_rdy_o, cw_rdy_o, out_vld_o, out_data_o, out_last_o,
           stat_vld_o, dec_fail_o, err_cnt_o
  );

endinterface

// File: rtl/rs_corr_lane.sv
// One output lane: XORs every valid table magnitude whose position matches this lane.
module rs_corr_lane
  import rs_dec_pkg::*;
(
  input  logic [POS_W-1:0] lane_pos_i,
  input  entry_t [T-1:0]   tbl_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     data_o
);

  // Accumulate all matches so duplicate positions combine cumulatively
  always_comb begin
    data_o = data_i;
    for (int unsigned i = 0; i < T; i++) begin
      if (tbl_i[i].vld && (tbl_i[i].pos == lane_pos_i)) data_o = data_o ^ tbl_i[i].y;
    end
  end

endmodule

// File: rtl/rs_err_correct.sv
// Collects Chien/Forney error events into a table, then XOR-corrects the buffered codeword beats.
module rs_err_correct
  import rs_dec_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  rs_err_correct_if.slave bus
);

  state_t               state_q, state_d;
  logic [3:0]           deg_q, deg_d;
  entry_t [T-1:0]       tbl_q, tbl_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic                 fail_q, fail_d;
  logic                 ovf_q, ovf_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 out_vld_q, out_vld_d;
  logic                 out_last_q, out_last_d;
  logic [P-1:0][W-1:0]  out_data_q, out_data_d;

  logic                 evt_rdy, cw_rdy, evt_acc, cw_acc, out_hs;
  entry_t [T-1:0]       tbl_eff;
  logic [P-1:0][POS_W-1:0] lane_pos;
  logic [P-1:0][W-1:0]  corr;

  // Handshake qualifiers and the fail-gated table seen by the lanes
  always_comb begin
    evt_rdy = (state_q == COLLECT);
    cw_rdy  = (state_q == CORRECT) && (!out_vld_q || bus.out_rdy_i);
    evt_acc = bus.evt_vld_i && evt_rdy;
    cw_acc  = bus.cw_vld_i && cw_rdy;
    out_hs  = out_vld_q && bus.out_rdy_i;
    tbl_eff = tbl_q;
    for (int unsigned i = 0; i < T; i++) tbl_eff[i].vld = tbl_q[i].vld && !(fail_q || ovf_q);
  end

  for (genvar j = 0; j < P; j++) begin : g_lane
    assign lane_pos[j] = POS_W'(int'(beat_q) * P + j);
    rs_corr_lane u_lane (
      .lane_pos_i (lane_pos[j]),
      .tbl_i      (tbl_eff),
      .data_i     (bus.cw_data_i[j]),
      .data_o     (corr[j])
    );
  end

  // Next-state: event collection, beat correction, start override applied last
  always_comb begin
    state_d    = state_q;
    deg_d      = deg_q;
    tbl_d      = tbl_q;
    err_cnt_d  = err_cnt_q;
    fail_d     = fail_q;
    ovf_d      = ovf_q;
    beat_d     = beat_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_data_d = out_data_q;

    if (state_q == COLLECT) begin
      if (evt_acc) begin
        if (err_cnt_q < CNT_W'(T)) begin
          for (int unsigned i = 0; i < T; i++) begin
            if (err_cnt_q == CNT_W'(i)) tbl_d[i] = '{vld: 1'b1, pos: bus.evt_pos_i, y: bus.evt_y_i};
          end
        end else begin
          ovf_d = 1'b1;
        end
        if (bus.evt_den_zero_i) fail_d = 1'b1;
        if (err_cnt_q != CNT_W'(T + 1)) err_cnt_d = err_cnt_q + 1'b1;
      end
      // Degree check uses the count including an event accepted alongside done
      if (bus.chien_done_i) begin
        state_d = CORRECT;
        if (err_cnt_d != deg_q) fail_d = 1'b1;
      end
    end

    if (out_hs) out_vld_d = 1'b0;
    if (cw_acc) begin
      out_vld_d  = 1'b1;
      out_data_d = corr;
      out_last_d = (beat_q == BEAT_W'(BEATS - 1));
      beat_d     = beat_q + 1'b1;
      if (beat_q == BEAT_W'(BEATS - 1)) state_d = IDLE;
    end

    if (bus.start_i) begin
      state_d    = COLLECT;
      deg_d      = bus.deg_i;
      for (int unsigned i = 0; i < T; i++) tbl_d[i].vld = 1'b0;
      err_cnt_d  = '0;
      fail_d     = 1'b0;
      ovf_d      = 1'b0;
      beat_d     = '0;
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      deg_q      <= '0;
      tbl_q      <= '0;
      err_cnt_q  <= '0;
      fail_q     <= 1'b0;
      ovf_q      <= 1'b0;
      beat_q     <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      deg_q      <= deg_d;
      tbl_q      <= tbl_d;
      err_cnt_q  <= err_cnt_d;
      fail_q     <= fail_d;
      ovf_q      <= ovf_d;
      beat_q     <= beat_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.evt_rdy_o  = evt_rdy;
  assign bus.cw_rdy_o   = cw_rdy;
  assign bus.out_vld_o  = out_vld_q;
  assign bus.out_data_o = out_data_q;
  assign bus.out_last_o = out_last_q;
  // Status fires on the last-beat handshake unless a new word is starting in that cycle
  assign bus.stat_vld_o = out_hs && out_last_q && !bus.start_i;
  assign bus.dec_fail_o = fail_q || ovf_q;
  assign bus.err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_rs_err_correct.sv
// Directed, table-driven bench for rs_err_correct.
module tb_rs_err_correct;
  import rs_dec_pkg::*;

  localparam int DW = P * W;

  typedef struct packed {
    logic [3:0]        deg;
    logic [3:0]        nevt;
    logic [11:0][9:0]  pos;
    logic [11:0][9:0]  y;
    logic [11:0]       den;
    logic              stall;
    logic              exp_fail;
    logic [3:0]        exp_cnt;
    logic [1:0]        ncorr;
    logic [2:0][4:0]   cb;
    logic [2:0][4:0]   cl;
    logic [2:0][9:0]   cm;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rs_err_correct_if bus();

  rs_err_correct dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [P-1:0][W-1:0] in_data [BEATS];
  logic [P-1:0][W-1:0] exp_data[BEATS];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start_i = 0; bus.deg_i = 0; bus.evt_vld_i = 0; bus.evt_pos_i = 0; bus.evt_y_i = 0;
    bus.evt_den_zero_i = 0; bus.chien_done_i = 0; bus.cw_vld_i = 0; bus.cw_data_i = '0;
    bus.out_rdy_i = 0;
  endtask

  task automatic gen_data(input vec_t v);
    for (int b = 0; b < BEATS; b++) begin
      for (int j = 0; j < P; j++) in_data[b][j] = W'($urandom_range(0, 1023));
      exp_data[b] = in_data[b];
    end
    for (int c = 0; c < int'(v.ncorr); c++)
      exp_data[v.cb[c]][v.cl[c]] = exp_data[v.cb[c]][v.cl[c]] ^ v.cm[c];
  endtask

  // Start pulse, stalled beat during COLLECT, events; last event coincides with done
  task automatic start_and_collect(input vec_t v);
    gen_data(v);
    @(negedge clk);
    bus.start_i = 1; bus.deg_i = v.deg; bus.cw_vld_i = 0; bus.out_rdy_i = 1;
    @(negedge clk);
    bus.start_i = 0; bus.cw_vld_i = 1; bus.cw_data_i = in_data[0];
    #1;
    chk("collect_cw_rdy", DW'(bus.cw_rdy_o), DW'(0));
    chk("collect_evt_rdy", DW'(bus.evt_rdy_o), DW'(1));
    for (int k = 0; k < int'(v.nevt); k++) begin
      bus.evt_vld_i = 1; bus.evt_pos_i = v.pos[k]; bus.evt_y_i = v.y[k];
      bus.evt_den_zero_i = v.den[k]; bus.chien_done_i = (k == int'(v.nevt) - 1);
      @(negedge clk);
    end
    bus.evt_vld_i = 0; bus.evt_den_zero_i = 0;
    if (v.nevt == 0) begin
      bus.chien_done_i = 1;
      @(negedge clk);
    end
    bus.chien_done_i = 0;
  endtask

  task automatic run_case(input int id, input vec_t v);
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    logic stalled = 0;
    logic [DW-1:0] held = '0;
    start_and_collect(v);
    while (out_idx < BEATS && cyc < 600) begin
      bus.cw_vld_i = (in_idx < BEATS);
      if (in_idx < BEATS) bus.cw_data_i = in_data[in_idx];
      bus.out_rdy_i = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) begin
        chk($sformatf("c%0d_hold_vld", id), DW'(bus.out_vld_o), DW'(1));
        chk($sformatf("c%0d_hold_data", id), DW'(bus.out_data_o), held);
      end
      if (bus.cw_vld_i && bus.cw_rdy_o) in_idx++;
      if (bus.out_vld_o && bus.out_rdy_i) begin
        chk($sformatf("c%0d_data_b%0d", id, out_idx), DW'(bus.out_data_o), DW'(exp_data[out_idx]));
        chk($sformatf("c%0d_last_b%0d", id, out_idx), DW'(bus.out_last_o), DW'(out_idx == BEATS - 1));
        chk($sformatf("c%0d_stat_b%0d", id, out_idx), DW'(bus.stat_vld_o), DW'(out_idx == BEATS - 1));
        if (out_idx == BEATS - 1) begin
          chk($sformatf("c%0d_fail", id), DW'(bus.dec_fail_o), DW'(v.exp_fail));
          chk($sformatf("c%0d_cnt", id), DW'(bus.err_cnt_o), DW'(v.exp_cnt));
        end
        out_idx++;
        stalled = 0;
      end else begin
        chk($sformatf("c%0d_stat_quiet", id), DW'(bus.stat_vld_o), DW'(0));
        stalled = bus.out_vld_o;
        held = DW'(bus.out_data_o);
      end
      cyc++;
      @(negedge clk);
    end
    if (out_idx < BEATS) begin
      checks++; errors++;
      $display("FAIL c%0d_timeout: got %0d beats expected %0d", id, out_idx, BEATS);
    end
    bus.cw_vld_i = 0; bus.out_rdy_i = 1;
    #1;
    chk($sformatf("c%0d_post_stat", id), DW'(bus.stat_vld_o), DW'(0));
    chk($sformatf("c%0d_post_fail", id), DW'(bus.dec_fail_o), DW'(v.exp_fail));
    chk($sformatf("c%0d_post_cnt", id), DW'(bus.err_cnt_o), DW'(v.exp_cnt));
    chk($sformatf("c%0d_post_cw_rdy", id), DW'(bus.cw_rdy_o), DW'(0));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, DW'({bus.evt_rdy_o, bus.cw_rdy_o, bus.out_vld_o, bus.out_last_o,
                             bus.stat_vld_o, bus.dec_fail_o, bus.err_cnt_o}), DW'(0));
    chk({name, "_data"}, DW'(bus.out_data_o), DW'(0));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vecs[i] = '0;
    // 0: no errors
    vecs[0].deg = 0; vecs[0].exp_cnt = 0;
    // 1: three errors at stream ends and beat boundary
    vecs[1].deg = 3; vecs[1].nevt = 3; vecs[1].exp_cnt = 3;
    vecs[1].pos[0] = 10'd0;   vecs[1].y[0] = 10'h001;
    vecs[1].pos[1] = 10'd33;  vecs[1].y[1] = 10'h3FF;
    vecs[1].pos[2] = 10'd543; vecs[1].y[2] = 10'h155;
    vecs[1].ncorr = 3;
    vecs[1].cb[0] = 0;  vecs[1].cl[0] = 0;  vecs[1].cm[0] = 10'h001;
    vecs[1].cb[1] = 1;  vecs[1].cl[1] = 1;  vecs[1].cm[1] = 10'h3FF;
    vecs[1].cb[2] = 16; vecs[1].cl[2] = 31; vecs[1].cm[2] = 10'h155;
    // 2: same with random output back-pressure
    vecs[2] = vecs[1]; vecs[2].stall = 1;
    // 3: Forney denominator zero
    vecs[3].deg = 1; vecs[3].nevt = 1; vecs[3].pos[0] = 10'd5; vecs[3].y[0] = 10'h0AB;
    vecs[3].den[0] = 1; vecs[3].exp_fail = 1; vecs[3].exp_cnt = 1;
    // 4: twelve events, table overflow
    vecs[4].deg = 11; vecs[4].nevt = 12; vecs[4].exp_fail = 1; vecs[4].exp_cnt = 12;
    for (int k = 0; k < 12; k++) begin
      vecs[4].pos[k] = 10'(10 + k); vecs[4].y[k] = 10'(1 + k);
    end
    // 5: duplicate position XORs; position 600 is beyond the codeword
    vecs[5].deg = 3; vecs[5].nevt = 3; vecs[5].exp_cnt = 3;
    vecs[5].pos[0] = 10'd40;  vecs[5].y[0] = 10'h0F0;
    vecs[5].pos[1] = 10'd40;  vecs[5].y[1] = 10'h00F;
    vecs[5].pos[2] = 10'd600; vecs[5].y[2] = 10'h3FF;
    vecs[5].ncorr = 1; vecs[5].cb[0] = 1; vecs[5].cl[0] = 8; vecs[5].cm[0] = 10'h0FF;
    // 6: count disagrees with degree
    vecs[6].deg = 2; vecs[6].nevt = 1; vecs[6].pos[0] = 10'd2; vecs[6].y[0] = 10'h005;
    vecs[6].exp_fail = 1; vecs[6].exp_cnt = 1;
    // 7: single error after an aborted word
    vecs[7].deg = 1; vecs[7].nevt = 1; vecs[7].pos[0] = 10'd100; vecs[7].y[0] = 10'h2AA;
    vecs[7].exp_cnt = 1; vecs[7].ncorr = 1;
    vecs[7].cb[0] = 3; vecs[7].cl[0] = 4; vecs[7].cm[0] = 10'h2AA;

    idle_inputs();
    rst_n = 0;
    bus.out_rdy_i = 1;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1;
    @(negedge clk);
    #1;
    chk("idle_evt_rdy", DW'(bus.evt_rdy_o), DW'(0));

    for (int i = 0; i < 7; i++) run_case(i, vecs[i]);

    // Abort word 1 after 8 beats; no status may appear for it
    begin
      int in_idx = 0;
      int cyc = 0;
      start_and_collect(vecs[1]);
      while (in_idx < 8 && cyc < 100) begin
        bus.cw_vld_i = 1; bus.cw_data_i = in_data[in_idx]; bus.out_rdy_i = 1;
        #1;
        chk("abort_stat_quiet", DW'(bus.stat_vld_o), DW'(0));
        if (bus.cw_rdy_o) in_idx++;
        cyc++;
        @(negedge clk);
      end
      if (in_idx < 8) begin
        checks++; errors++;
        $display("FAIL abort_timeout: got %0d beats expected 8", in_idx);
      end
      bus.cw_vld_i = 0;
    end
    run_case(7, vecs[7]);

    // Reset asserted mid-CORRECT with an output beat held
    begin
      start_and_collect(vecs[3]);
      bus.cw_vld_i = 1; bus.cw_data_i = in_data[0]; bus.out_rdy_i = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("midrst_pre_vld", DW'(bus.out_vld_o), DW'(1));
      rst_n = 0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      idle_inputs();
      bus.out_rdy_i = 1;
      #1;
      chk("midrst_stat", DW'(bus.stat_vld_o), DW'(0));
      @(negedge clk);
      rst_n = 1;
    end
    run_case(8, vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
